// File: rtl/shape_processor_ctrl_bank.sv
// rtl/shape_processor_ctrl_bank.sv - multi-channel CTRL register bank with queued, validated writes
module shape_processor_ctrl_bank #(
    parameter int NUM_CHANNELS  = 4,
    parameter int FIFO_DEPTH    = 4,
    parameter int ERR_CNT_WIDTH = 8,
    localparam int CW = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      write_valid,
    output logic                      write_ready,
    input  logic [CW-1:0]             write_channel,
    input  logic [31:0]               write_data,
    input  logic                      apply_hold,
    input  logic [CW-1:0]             read_channel,
    output logic [31:0]               read_data,
    output logic [2*NUM_CHANNELS-1:0] ctrl_shape,
    output logic [6*NUM_CHANNELS-1:0] ctrl_operation,
    output logic [NUM_CHANNELS-1:0]   update_pulse,
    output logic [ERR_CNT_WIDTH-1:0]  err_count,
    input  logic                      err_clear,
    output logic                      busy
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int EW = CW + 8;

    localparam logic [1:0] SHAPE_RECT = 2'b01;
    localparam logic [1:0] SHAPE_TRI  = 2'b10;
    localparam logic [1:0] SHAPE_KEEP = 2'b11;
    localparam logic [5:0] OP_PERIM   = 6'h00;
    localparam logic [5:0] OP_AREA    = 6'h01;
    localparam logic [5:0] OP_SQUARE  = 6'h10;
    localparam logic [5:0] OP_EQUI    = 6'h20;
    localparam logic [5:0] OP_ISO     = 6'h21;
    localparam logic [5:0] OP_KEEP    = 6'h3F;

    logic [EW-1:0]             mem [FIFO_DEPTH];
    logic [AW:0]               wr_ptr, rd_ptr;
    logic                      empty, full, push, pop;
    logic [CW-1:0]             head_ch, head_idx, rd_idx;
    logic [1:0]                head_shape, cur_shape, res_shape;
    logic [5:0]                head_op, cur_op, res_op;
    logic                      ch_ok, op_ok, combo_ok, commit, discard, rd_ok;
    logic [2*NUM_CHANNELS-1:0] shape_q;
    logic [6*NUM_CHANNELS-1:0] op_q;
    logic [NUM_CHANNELS-1:0]   pulse_q;
    logic [ERR_CNT_WIDTH-1:0]  err_q;
    logic                      unused_bits;

    assign unused_bits = ^{write_data[31:18], write_data[15:6]};

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign empty       = (wr_ptr == rd_ptr);
    assign full        = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign push        = write_valid && !full;
    assign pop         = !empty && !apply_hold;
    assign write_ready = !full;
    assign busy        = !empty;

    assign {head_ch, head_shape, head_op} = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= {write_channel, write_data[17:16], write_data[5:0]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // Head entry is resolved against the live committed state of its channel.
    always_comb begin
        ch_ok     = 32'(head_ch) < NUM_CHANNELS;
        head_idx  = ch_ok ? head_ch : '0;
        cur_shape = shape_q[2*head_idx +: 2];
        cur_op    = op_q[6*head_idx +: 6];
        case (head_op)
            OP_PERIM, OP_AREA, OP_SQUARE, OP_EQUI, OP_ISO, OP_KEEP: op_ok = 1'b1;
            default:                                                op_ok = 1'b0;
        endcase
        res_shape = (head_shape == SHAPE_KEEP) ? cur_shape : head_shape;
        res_op    = (head_op == OP_KEEP) ? cur_op : head_op;
        case (res_op)
            OP_PERIM, OP_AREA: combo_ok = 1'b1;
            OP_SQUARE:         combo_ok = (res_shape == SHAPE_RECT);
            OP_EQUI, OP_ISO:   combo_ok = (res_shape == SHAPE_TRI);
            default:           combo_ok = 1'b0;
        endcase
        commit  = pop && ch_ok && (head_shape != 2'b00) && op_ok && combo_ok;
        discard = pop && !commit;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shape_q <= {NUM_CHANNELS{SHAPE_RECT}};
            op_q    <= '0;
            pulse_q <= '0;
        end else begin
            pulse_q <= '0;
            if (commit) begin
                shape_q[2*head_idx +: 2] <= res_shape;
                op_q[6*head_idx +: 6]    <= res_op;
                pulse_q[head_idx]        <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= '0;
        end else if (err_clear) begin
            err_q <= '0;
        end else if (discard && (err_q != '1)) begin
            err_q <= err_q + ERR_CNT_WIDTH'(1);
        end
    end

    always_comb begin
        rd_ok     = 32'(read_channel) < NUM_CHANNELS;
        rd_idx    = rd_ok ? read_channel : '0;
        read_data = '0;
        if (rd_ok) begin
            read_data[17:16] = shape_q[2*rd_idx +: 2];
            read_data[5:0]   = op_q[6*rd_idx +: 6];
        end
    end

    assign ctrl_shape     = shape_q;
    assign ctrl_operation = op_q;
    assign update_pulse   = pulse_q;
    assign err_count      = err_q;

endmodule
